dmem_ctrl: RTL and testbench

DMEM_CTRL -- requirements
Module: dmem_ctrl

---
 rtl/dmem_ctrl_pkg.sv | 31 +++
 rtl/dmem_sram_array.sv | 38 +++
 rtl/dmem_ctrl.sv | 174 +++++++++++++++++
 tb/tb_dmem_ctrl.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_ctrl_pkg.sv
// Shared pcore interface definitions: dbus request/response structs, the data
// memory controller state type and its default geometry/timing constants.
package dmem_ctrl_pkg;

  // Default data memory geometry and access timing
  localparam int unsigned DMEM_DEPTH_DEFAULT  = 4096;  // 32-bit words (16 KB)
  localparam int unsigned WAIT_STATES_DEFAULT = 1;     // extra cycles before ack

  // Request from the dbus address decoder to a peripheral
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] w_data;
    logic [3:0]  sel_byte;
    logic        w_en;
    logic        req;
  } type_dbus2peri_s;

  // Response from a peripheral to the dbus read mux
  typedef struct packed {
    logic [31:0] r_data;
    logic        ack;
  } type_peri2dbus_s;

  // Data memory controller FSM states
  typedef enum logic [1:0] {
    DMEM_IDLE = 2'd0,
    DMEM_WAIT = 2'd1,
    DMEM_ACK  = 2'd2
  } type_dmem_state_e;

endpackage

// File: rtl/dmem_sram_array.sv
// Synchronous single-port RAM with per-lane write enables and registered read.
// Four lanes of LANE_W bits each (8 for data only, 9 when a parity bit rides
// along with each byte). Contents are never reset.
module dmem_sram_array #(
  parameter int unsigned DEPTH  = 4096,
  parameter int unsigned LANE_W = 8,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  en_i,
  input  logic                  we_i,
  input  logic [3:0]            be_i,
  input  logic [AW-1:0]         addr_i,
  input  logic [4*LANE_W-1:0]   wdata_i,
  output logic [4*LANE_W-1:0]   rdata_o
);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [LANE_W-1:0] mem_q [DEPTH];
      logic [LANE_W-1:0] rd_q;

      // One lane: byte-enabled write and read-before-write registered output
      always_ff @(posedge clk) begin
        if (en_i) begin
          if (we_i && be_i[gi]) begin
            mem_q[addr_i] <= wdata_i[gi*LANE_W +: LANE_W];
          end
          rd_q <= mem_q[addr_i];
        end
      end

      assign rdata_o[gi*LANE_W +: LANE_W] = rd_q;
    end
  endgenerate

endmodule

// File: rtl/dmem_ctrl.sv
// Data memory controller: accepts one dbus transaction at a time, waits
// WAIT_STATES cycles, then performs the array access and acks for one cycle.
// Optional feature macro: DMEM_PARITY_EN (per-byte even parity, parity_err_o).
module dmem_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int unsigned DMEM_DEPTH  = DMEM_DEPTH_DEFAULT,
  parameter int unsigned WAIT_STATES = WAIT_STATES_DEFAULT
) (
  input  logic            rst_n,
  input  logic            clk,
  input  type_dbus2peri_s dbus2dmem_i,
  input  logic            dmem_sel_i,
  output type_peri2dbus_s dmem2dbus_o
`ifdef DMEM_PARITY_EN
  ,
  output logic            parity_err_o
`endif
);

  localparam int unsigned AW = $clog2(DMEM_DEPTH);
`ifdef DMEM_PARITY_EN
  localparam int unsigned LANE_W = 9;
`else
  localparam int unsigned LANE_W = 8;
`endif

  localparam logic [1:0] ST_IDLE = DMEM_IDLE;
  localparam logic [1:0] ST_WAIT = DMEM_WAIT;
  localparam logic [1:0] ST_ACK  = DMEM_ACK;

  // Counter preload; the WAIT_STATES=0 value is never used
  localparam logic [3:0] CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  logic [1:0]    state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    sel_q, sel_d;
  logic          wen_q, wen_d;
  logic          run_q;
  logic          accept;
  logic          is_ack;

  logic                ram_en;
  logic [4*LANE_W-1:0] ram_wdata;
  logic [4*LANE_W-1:0] ram_rdata;
  logic [31:0]         rd_word;

  // Only the word-index bits of the address matter; the rest are dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{dbus2dmem_i.addr[31:AW+2], dbus2dmem_i.addr[1:0]};

  // run_q keeps the controller from accepting in the first cycle after reset
  // release, so a request held through reset cannot touch the array.
  assign accept = run_q && (state_q == ST_IDLE) && dmem_sel_i && dbus2dmem_i.req;
  assign is_ack = (state_q == ST_ACK);

  // Next-state and wait counter logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (WAIT_STATES > 0) begin
            state_d = ST_WAIT;
            cnt_d   = CNT_INIT;
          end else begin
            state_d = ST_ACK;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_ACK;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_ACK: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Capture the request fields on accept, otherwise hold them
  always_comb begin
    addr_d  = addr_q;
    wdata_d = wdata_q;
    sel_d   = sel_q;
    wen_d   = wen_q;
    if (accept) begin
      addr_d  = dbus2dmem_i.addr[AW+1:2];
      wdata_d = dbus2dmem_i.w_data;
      sel_d   = dbus2dmem_i.sel_byte;
      wen_d   = dbus2dmem_i.w_en;
    end
  end

  // FSM, counter and request latches
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      sel_q   <= 4'd0;
      wen_q   <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      sel_q   <= sel_d;
      wen_q   <= wen_d;
      run_q   <= 1'b1;
    end
  end

  // The array is accessed on the edge that enters ACK, so the registered
  // read data is valid exactly in the ACK cycle. The _d values are used so
  // that the zero-wait path (IDLE->ACK) sees the request being accepted.
  assign ram_en = (state_d == ST_ACK);

  logic [3:0] lane_err;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane_map
`ifdef DMEM_PARITY_EN
      // Even parity: the stored lane always holds an even number of ones
      assign ram_wdata[gi*LANE_W +: LANE_W] = {^wdata_d[gi*8 +: 8], wdata_d[gi*8 +: 8]};
      assign lane_err[gi]                   = ^ram_rdata[gi*LANE_W +: LANE_W];
`else
      assign ram_wdata[gi*LANE_W +: LANE_W] = wdata_d[gi*8 +: 8];
      assign lane_err[gi]                   = 1'b0;
`endif
      assign rd_word[gi*8 +: 8] = ram_rdata[gi*LANE_W +: 8];
    end
  endgenerate

  dmem_sram_array #(
    .DEPTH  (DMEM_DEPTH),
    .LANE_W (LANE_W)
  ) u_array (
    .clk     (clk),
    .en_i    (ram_en),
    .we_i    (wen_d),
    .be_i    (sel_d),
    .addr_i  (addr_d),
    .wdata_i (ram_wdata),
    .rdata_o (ram_rdata)
  );

  // Response: ack only in ACK, read data only for reads in ACK
  always_comb begin
    dmem2dbus_o.ack    = is_ack;
    dmem2dbus_o.r_data = (is_ack && !wen_q) ? rd_word : 32'd0;
  end

`ifdef DMEM_PARITY_EN
  assign parity_err_o = is_ack && !wen_q && (|lane_err);
`else
  logic unused_lane_err;
  assign unused_lane_err = ^lane_err;
`endif

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: one instance with WAIT_STATES=1 for the
// directed and random traffic, one with WAIT_STATES=0 for the held-request case.
module tb_dmem_ctrl;
  import dmem_ctrl_pkg::*;

  localparam int DEPTH = 4096;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  type_dbus2peri_s bus1, bus0;
  logic            sel1, sel0;
  type_peri2dbus_s out1, out0;
  logic            perr1, perr0;

  int n_checks = 0;
  int n_errors = 0;

  // Reference memory: word index -> contents, only for words the bench wrote
  bit [31:0] model_mem [int];

  dmem_ctrl #(.DMEM_DEPTH(DEPTH), .WAIT_STATES(1)) dut1 (
    .rst_n(rst_n), .clk(clk), .dbus2dmem_i(bus1), .dmem_sel_i(sel1), .dmem2dbus_o(out1)
`ifdef DMEM_PARITY_EN
    , .parity_err_o(perr1)
`endif
  );

  dmem_ctrl #(.DMEM_DEPTH(DEPTH), .WAIT_STATES(0)) dut0 (
    .rst_n(rst_n), .clk(clk), .dbus2dmem_i(bus0), .dmem_sel_i(sel0), .dmem2dbus_o(out0)
`ifdef DMEM_PARITY_EN
    , .parity_err_o(perr0)
`endif
  );

`ifndef DMEM_PARITY_EN
  assign perr1 = 1'b0;
  assign perr0 = 1'b0;
`endif

  function automatic int widx(input logic [31:0] addr);
    return int'((addr / 4) % DEPTH);
  endfunction

  function automatic void model_write(input logic [31:0] addr, input logic [31:0] wd,
                                      input logic [3:0] sel);
    bit [31:0] w;
    w = model_mem.exists(widx(addr)) ? model_mem[widx(addr)] : 32'd0;
    for (int b = 0; b < 4; b++)
      if (sel[b]) w[8*b +: 8] = wd[8*b +: 8];
    model_mem[widx(addr)] = w;
  endfunction

  // One transaction on the WAIT_STATES=1 instance. lat counts cycles from the
  // accept edge to the ack cycle (0 means no ack within the budget).
  task automatic do_txn1(input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] sel,
                         input bit we, output int lat, output logic [31:0] rd, output logic perr,
                         output logic ack_after, output logic [31:0] rd_after, output logic perr_after);
    @(negedge clk);
    bus1.addr = addr; bus1.w_data = wd; bus1.sel_byte = sel; bus1.w_en = we; bus1.req = 1'b1;
    sel1 = 1'b1;
    @(posedge clk);
    #1;
    bus1.req = 1'b0; sel1 = 1'b0;
    lat = 0; rd = 32'd0; perr = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (out1.ack === 1'b1) begin
        lat = n; rd = out1.r_data; perr = perr1;
        break;
      end
    end
    @(negedge clk);
    ack_after = out1.ack; rd_after = out1.r_data; perr_after = perr1;
    $display("txn addr=%08h we=%0d sel=%b wd=%08h lat=%0d rd=%08h perr=%0d",
             addr, we, sel, wd, lat, rd, perr);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus1 = '0; bus0 = '0; sel1 = 1'b0; sel0 = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (out1.ack !== 1'b0 || out1.r_data !== 32'd0) begin
      n_errors++; $display("FAIL reset_out1: ack=%b r_data=%08h required ack=0 r_data=0", out1.ack, out1.r_data);
    end
    n_checks++;
    if (out0.ack !== 1'b0 || out0.r_data !== 32'd0) begin
      n_errors++; $display("FAIL reset_out0: ack=%b r_data=%08h required ack=0 r_data=0", out0.ack, out0.r_data);
    end
`ifdef DMEM_PARITY_EN
    n_checks++;
    if (perr1 !== 1'b0) begin
      n_errors++; $display("FAIL reset_perr: got %b required 0", perr1);
    end
`endif
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_sw_lw();
    int lat; logic [31:0] rd, rda; logic pe, aa, pea;
    do_txn1(32'h0000_0010, 32'hDEAD_BEEF, 4'b1111, 1'b1, lat, rd, pe, aa, rda, pea);
    model_write(32'h10, 32'hDEAD_BEEF, 4'b1111);
    n_checks++;
    if (lat !== 2) begin n_errors++; $display("FAIL sw_latency: got %0d required 2", lat); end
    n_checks++;
    if (rd !== 32'd0) begin n_errors++; $display("FAIL sw_rdata: got %08h required 0", rd); end
    n_checks++;
    if (aa !== 1'b0) begin n_errors++; $display("FAIL sw_ack_one_cycle: ack after=%b required 0", aa); end
    do_txn1(32'h0000_0010, 32'h0, 4'b1111, 1'b0, lat, rd, pe, aa, rda, pea);
    n_checks++;
    if (lat !== 2) begin n_errors++; $display("FAIL lw_latency: got %0d required 2", lat); end
    n_checks++;
    if (rd !== model_mem[widx(32'h10)]) begin
      n_errors++; $display("FAIL lw_rdata: got %08h required %08h", rd, model_mem[widx(32'h10)]);
    end
    n_checks++;
    if (rda !== 32'd0) begin n_errors++; $display("FAIL lw_rdata_after_ack: got %08h required 0", rda); end
  endtask

  task automatic test_byte_write();
    int lat; logic [31:0] rd, rda; logic pe, aa, pea;
    do_txn1(32'h0000_0013, 32'h1111_1111, 4'b1000, 1'b1, lat, rd, pe, aa, rda, pea);
    model_write(32'h13, 32'h1111_1111, 4'b1000);
    do_txn1(32'h0000_0010, 32'h0, 4'b1111, 1'b0, lat, rd, pe, aa, rda, pea);
    n_checks++;
    if (rd !== 32'h11AD_BEEF || rd !== model_mem[widx(32'h10)]) begin
      n_errors++; $display("FAIL sb_merge: got %08h required %08h", rd, 32'h11AD_BEEF);
    end
    // Write with no byte enables: acks, leaves the word alone
    do_txn1(32'h0000_0010, 32'h5555_AAAA, 4'b0000, 1'b1, lat, rd, pe, aa, rda, pea);
    n_checks++;
    if (lat !== 2) begin n_errors++; $display("FAIL sel0_ack: latency got %0d required 2", lat); end
    do_txn1(32'h0000_0010, 32'h0, 4'b1111, 1'b0, lat, rd, pe, aa, rda, pea);
    n_checks++;
    if (rd !== model_mem[widx(32'h10)]) begin
      n_errors++; $display("FAIL sel0_noop: got %08h required %08h", rd, model_mem[widx(32'h10)]);
    end
  endtask

  task automatic test_wrap();
    int lat; logic [31:0] rd, rda; logic pe, aa, pea;
    do_txn1(32'h0000_4000, 32'h1234_5678, 4'b1111, 1'b1, lat, rd, pe, aa, rda, pea);
    model_write(32'h4000, 32'h1234_5678, 4'b1111);
    do_txn1(32'h0000_0000, 32'h0, 4'b1111, 1'b0, lat, rd, pe, aa, rda, pea);
    n_checks++;
    if (rd !== 32'h1234_5678 || rd !== model_mem[widx(32'h0)]) begin
      n_errors++; $display("FAIL wrap: got %08h required %08h", rd, 32'h1234_5678);
    end
  endtask

  task automatic test_reset_mid();
    int lat; int acks; logic [31:0] rd, rda; logic pe, aa, pea;
    do_txn1(32'h0000_0020, 32'hA5A5_5A5A, 4'b1111, 1'b1, lat, rd, pe, aa, rda, pea);
    model_write(32'h20, 32'hA5A5_5A5A, 4'b1111);
    @(negedge clk);
    bus1.addr = 32'h20; bus1.w_data = 32'hFFFF_FFFF; bus1.sel_byte = 4'b1111;
    bus1.w_en = 1'b1; bus1.req = 1'b1; sel1 = 1'b1;
    @(posedge clk);
    #1;
    bus1.req = 1'b0; sel1 = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    acks = (out1.ack === 1'b1) ? 1 : 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (out1.ack !== 1'b0) acks++;
    end
    n_checks++;
    if (acks !== 0) begin n_errors++; $display("FAIL reset_mid_ack: got %0d acks required 0", acks); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    do_txn1(32'h0000_0020, 32'h0, 4'b1111, 1'b0, lat, rd, pe, aa, rda, pea);
    n_checks++;
    if (rd !== model_mem[widx(32'h20)]) begin
      n_errors++; $display("FAIL reset_mid_content: got %08h required %08h", rd, model_mem[widx(32'h20)]);
    end
  endtask

  task automatic test_hold_ws0();
    logic [3:0] acks;
    logic [31:0] wd;
    wd = $urandom;
    @(negedge clk);
    bus0.addr = 32'h40; bus0.w_data = wd; bus0.sel_byte = 4'b1111; bus0.w_en = 1'b1; bus0.req = 1'b1;
    sel0 = 1'b1;
    @(negedge clk); acks[0] = out0.ack;
    @(negedge clk); acks[1] = out0.ack;
    @(posedge clk);
    #1;
    bus0.req = 1'b0; sel0 = 1'b0;
    @(negedge clk); acks[2] = out0.ack;
    @(negedge clk); acks[3] = out0.ack;
    $display("txn ws0 hold addr=00000040 wd=%08h acks=%b", wd, acks);
    n_checks++;
    if (acks[1:0] !== 2'b01) begin
      n_errors++; $display("FAIL ws0_single_ack: ack cycles 1..2 got %b required 10 (cycle1 first)", {acks[0], acks[1]});
    end
    n_checks++;
    if (acks[3:2] !== 2'b01) begin
      n_errors++; $display("FAIL ws0_reaccept_after_turnaround: ack cycles 3..4 got %b required 10", {acks[2], acks[3]});
    end
    // Zero-wait read back: ack and data in the cycle after accept
    @(negedge clk);
    bus0.w_en = 1'b0; bus0.req = 1'b1; sel0 = 1'b1;
    @(posedge clk);
    #1;
    bus0.req = 1'b0; sel0 = 1'b0;
    @(negedge clk);
    n_checks++;
    if (out0.ack !== 1'b1 || out0.r_data !== wd) begin
      n_errors++; $display("FAIL ws0_read: ack=%b r_data=%08h required ack=1 r_data=%08h", out0.ack, out0.r_data, wd);
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    int lat; logic [31:0] rd, rda, addr, wd; logic pe, aa, pea; logic [3:0] sel; bit we;
    int errs_before;
    errs_before = n_errors;
    for (int w = 0; w < 8; w++) begin
      wd = $urandom;
      do_txn1(32'h100 + 32'(4*w), wd, 4'b1111, 1'b1, lat, rd, pe, aa, rda, pea);
      model_write(32'h100 + 32'(4*w), wd, 4'b1111);
    end
    for (int t = 0; t < 40; t++) begin
      addr = {18'($urandom), 12'(64 + $urandom_range(0, 7)), 2'($urandom)};
      wd   = $urandom;
      sel  = 4'($urandom);
      we   = ($urandom_range(0, 1) == 1);
      do_txn1(addr, wd, sel, we, lat, rd, pe, aa, rda, pea);
      n_checks++;
      if (lat !== 2 || aa !== 1'b0 || rda !== 32'd0) begin
        n_errors++; $display("FAIL rand_handshake[%0d]: lat=%0d ack_after=%b rd_after=%08h required 2/0/0", t, lat, aa, rda);
      end
      if (we) begin
        model_write(addr, wd, sel);
        n_checks++;
        if (rd !== 32'd0) begin n_errors++; $display("FAIL rand_wr_rdata[%0d]: got %08h required 0", t, rd); end
      end else begin
        n_checks++;
        if (rd !== model_mem[widx(addr)]) begin
          n_errors++; $display("FAIL rand_rd[%0d]: addr=%08h got %08h required %08h", t, addr, rd, model_mem[widx(addr)]);
        end
`ifdef DMEM_PARITY_EN
        n_checks++;
        if (pe !== 1'b0) begin n_errors++; $display("FAIL rand_parity[%0d]: got %b required 0", t, pe); end
`endif
      end
    end
    $display("random traffic done, new errors %0d", n_errors - errs_before);
  endtask

`ifdef DMEM_PARITY_EN
  task automatic test_parity();
    int lat; logic [31:0] rd, rda; logic pe, aa, pea;
    do_txn1(32'h0000_0030, 32'h0F0F_1234, 4'b1111, 1'b1, lat, rd, pe, aa, rda, pea);
    do_txn1(32'h0000_0030, 32'h0, 4'b1111, 1'b0, lat, rd, pe, aa, rda, pea);
    n_checks++;
    if (pe !== 1'b0) begin n_errors++; $display("FAIL parity_clean: got %b required 0", pe); end
    dut1.u_array.g_lane[0].mem_q[12][0] = ~dut1.u_array.g_lane[0].mem_q[12][0];
    do_txn1(32'h0000_0030, 32'h0, 4'b1111, 1'b0, lat, rd, pe, aa, rda, pea);
    n_checks++;
    if (lat !== 2 || pe !== 1'b1) begin
      n_errors++; $display("FAIL parity_err_with_ack: lat=%0d perr=%b required 2/1", lat, pe);
    end
    n_checks++;
    if (pea !== 1'b0) begin n_errors++; $display("FAIL parity_err_one_cycle: got %b required 0", pea); end
    n_checks++;
    if (rd !== 32'h0F0F_1235) begin n_errors++; $display("FAIL parity_rdata: got %08h required 0f0f1235", rd); end
  endtask
`endif

  initial begin
    test_reset();
    test_sw_lw();
    test_byte_write();
    test_wrap();
    test_reset_mid();
    test_hold_ws0();
    test_random();
`ifdef DMEM_PARITY_EN
    test_parity();
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Absolute time bound so the run always ends
  initial begin
    #500000;
    $display("FAIL timeout: simulation still running at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
